pe_out_framer: RTL

Downstream stage of the HLS PE wrapper: consumes the PE's 64-bit result stream and turns it into packets for the cluster network. Payload words are buffered in an internal FIFO. Each packet is a header word followed by its payload words. A packet closes when PKT_WORDS words have accumulated, or when the stream has gone idle for TIMEOUT cycles with at least one word buffered. Both ports use the PE's valid/backpressure convention.

---
 rtl/opfc_pkt_pkg.sv | 32 +++
 rtl/pkt_sync_fifo.sv | 67 ++++++
 rtl/pe_out_framer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/opfc_pkt_pkg.sv
// Shared definitions for the PE output framer: header field layout and FSM states.
package opfc_pkt_pkg;

  localparam int WORD_W       = 64;
  localparam int FIELD_W      = 16;
  localparam int HDR_DEST_LSB = 48;
  localparam int HDR_SRC_LSB  = 32;
  localparam int HDR_LEN_LSB  = 16;
  localparam int HDR_SEQ_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] build_header(
    input logic [FIELD_W-1:0] dest,
    input logic [FIELD_W-1:0] src,
    input logic [FIELD_W-1:0] len,
    input logic [FIELD_W-1:0] seq
  );
    logic [WORD_W-1:0] h;
    h = '0;
    h[HDR_DEST_LSB +: FIELD_W] = dest;
    h[HDR_SRC_LSB  +: FIELD_W] = src;
    h[HDR_LEN_LSB  +: FIELD_W] = len;
    h[HDR_SEQ_LSB  +: FIELD_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO on an inferred RAM with registered read.
// The head is re-read every cycle from the next read address; a same-cycle write is bypassed.
module pkt_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             byp_q, byp_d;
  logic [WIDTH-1:0] byp_data_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    wr_en    = push & ~full;
    rd_en    = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    // RAM read returns the old contents when the head slot is written this cycle
    byp_d    = wr_en && (wr_ptr_q == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= din;
    end
    rd_data_q  <= mem[rd_ptr_d];
    byp_data_q <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      byp_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      byp_q    <= byp_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = byp_q ? byp_data_q : rd_data_q;

endmodule

// File: rtl/pe_out_framer.sv
// Packetises the PE result stream: buffers payload, closes on full size or idle timeout,
// then emits a header word followed by the buffered payload words.
module pe_out_framer
  import opfc_pkt_pkg::*;
#(
  parameter int PKT_WORDS = 64,
  parameter int TIMEOUT   = 256,
  parameter int DEPTH     = 512
) (
  input  logic        CLK,
  input  logic        SYS_RST,
  input  logic [15:0] DEST_ID,
  input  logic [15:0] SRC_ID,
  input  logic [63:0] D,
  input  logic        D_VALID,
  output logic        D_BP,
  output logic [63:0] Q,
  output logic        Q_VALID,
  input  logic        Q_BP
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [FIELD_W-1:0] ACC_FULL  = FIELD_W'(PKT_WORDS);
  localparam logic [IW-1:0]      IDL_MAX   = IW'(TIMEOUT);
  localparam logic [CW-1:0]      FIFO_FULL = CW'(DEPTH);

  state_e              state_q, state_d;
  logic [FIELD_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]       idl_q, idl_d;
  logic [FIELD_W-1:0]  len_q, len_d;
  logic [FIELD_W-1:0]  rem_q, rem_d;
  logic [FIELD_W-1:0]  seq_q, seq_d;
  logic                d_bp_q, d_bp_d;

  logic                close;
  logic                pop;
  logic [WORD_W-1:0]   fifo_head;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       fifo_count_next;
  logic                fifo_empty;

  pkt_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_payload_fifo (
    .clk   (CLK),
    .srst  (SYS_RST),
    .push  (D_VALID),
    .din   (D),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    close   = 1'b0;
    pop     = 1'b0;
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    seq_d   = seq_q;

    unique case (state_q)
      ST_IDLE: begin
        if ((acc_q == ACC_FULL) || ((acc_q != '0) && (idl_q == IDL_MAX))) begin
          close   = 1'b1;
          len_d   = acc_q;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!Q_BP) begin
          rem_d   = len_q;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!Q_BP && !fifo_empty) begin
          pop   = 1'b1;
          rem_d = rem_q - FIELD_W'(1);
          if (rem_q == FIELD_W'(1)) begin
            seq_d   = seq_q + FIELD_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A word arriving in the close cycle is the first word of the next packet
    acc_d = close ? FIELD_W'(D_VALID) : acc_q + FIELD_W'(D_VALID);

    if (D_VALID || close || (acc_q == '0)) begin
      idl_d = '0;
    end else if (idl_q == IDL_MAX) begin
      idl_d = idl_q;
    end else begin
      idl_d = idl_q + IW'(1);
    end

    // Backpressure must already be exact in the cycle it is seen, so look one step ahead
    fifo_count_next = fifo_count + CW'(D_VALID) - CW'(pop);
    d_bp_d          = (acc_d == ACC_FULL) || (fifo_count_next == FIFO_FULL);
  end

  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idl_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      seq_q   <= '0;
      d_bp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idl_q   <= idl_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      d_bp_q  <= d_bp_d;
    end
  end

  always_comb begin
    Q = '0;
    unique case (state_q)
      ST_HDR:  Q = build_header(DEST_ID, SRC_ID, len_q, seq_q);
      ST_PAY:  Q = fifo_head;
      default: Q = '0;
    endcase
  end

  assign Q_VALID = ((state_q == ST_HDR) || (state_q == ST_PAY)) && !Q_BP;
  assign D_BP    = d_bp_q;

endmodule
